mem_port_arbiter: RTL and testbench

- Shares the single SRAM-like bus port between instruction fetch (IF) and data access (MEM).
- Sequences each transaction through its address and data handshake phases.
- Generates stallreq_from_if / stallreq_from_mem for the hazard unit.
- Holds returned read data while the pipeline is stalled for other reasons, and discards responses belonging to flushed instructions.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_slot.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the IF/MEM bus port arbiter:
//   arb_state_e        - arbiter FSM state encoding (ARB_IDLE .. ARB_I_DATA)
//   SIZE_BYTE/HALF/WORD - bus transfer size codes carried on *_size
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_D_ADDR = 3'd1,
        ARB_D_DATA = 3'd2,
        ARB_I_ADDR = 3'd3,
        ARB_I_DATA = 3'd4
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_slot.sv
// arb_req_slot
// Per-requester completion holder. Remembers that the requester's current
// transaction has finished (done) and the read data it returned, keeping
// both while the pipeline is stalled. A transaction caught by an exception
// flush is marked for dropping so its response is consumed but ignored.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   active       - arbiter currently owns a bus transaction for this requester
//   complete     - that transaction's data phase finishes this cycle
//   capture      - keep bus_rdata on completion (0 for stores)
//   flush        - exception flush this cycle
//   flush_idle   - flush arrived while the arbiter is idle
//   cpu_stall    - pipeline globally stalled
//   bus_rdata    - read data from the bus
//   done         - transaction finished and not yet consumed by the pipeline
//   rdata        - held read data
module arb_req_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              active,
    input  logic              complete,
    input  logic              capture,
    input  logic              flush,
    input  logic              flush_idle,
    input  logic              cpu_stall,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    logic drop;

    // A flush that lands in the completing cycle drops the response just
    // like one that arrived earlier. done is released as soon as the
    // pipeline moves (cpu_stall low) or an idle-time flush kills the stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            done  <= 1'b0;
            drop  <= 1'b0;
            rdata <= '0;
        end else if (complete) begin
            drop <= 1'b0;
            if (!(drop || flush)) begin
                done <= 1'b1;
                if (capture) begin
                    rdata <= bus_rdata;
                end
            end
        end else begin
            if (active && flush) begin
                drop <= 1'b1;
            end
            if (flush_idle || !cpu_stall) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one SRAM-like bus port between instruction fetch and data access.
// Data requests win over fetches (they belong to the older instruction).
// Each transaction runs an address phase (bus_req until bus_addr_ok) then a
// data phase (until bus_data_ok); both may complete in the same cycle.
// Ports:
//   clk, resetn                  - clock, asynchronous active-low reset
//   inst_req/inst_addr           - fetch request; inst_rdata holds the result
//   stallreq_from_if             - fetch still outstanding
//   data_req/wr/size/addr/wdata  - load/store request; data_rdata holds loads
//   stallreq_from_mem            - data access still outstanding
//   cpu_stall, except_flush      - pipeline stall and exception flush
//   bus_*                        - shared bus port (registered request fields)
// Optional build macro ARB_PERF_CNT_EN adds perf_if_wait / perf_mem_wait,
// free-running 32-bit counts of cycles spent with each stall request high.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              stallreq_from_if,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stallreq_from_mem,
    input  logic              cpu_stall,
    input  logic              except_flush,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_mem_wait
`endif
);

    arb_state_e        state_q, state_d;
    logic              req_d, wr_d;
    logic [1:0]        size_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              inst_done, data_done;
    logic              inst_active, data_active;
    logic              inst_complete, data_complete;
    logic              flush_idle;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ARB_IDLE;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state_q   <= state_d;
            bus_req   <= req_d;
            bus_wr    <= wr_d;
            bus_size  <= size_d;
            bus_addr  <= addr_d;
            bus_wdata <= wdata_d;
        end
    end

    // Request fields are latched when leaving IDLE and held until the next
    // transaction, so the bus sees stable values for the whole handshake.
    always_comb begin
        state_d = state_q;
        req_d   = bus_req;
        wr_d    = bus_wr;
        size_d  = bus_size;
        addr_d  = bus_addr;
        wdata_d = bus_wdata;
        case (state_q)
            ARB_IDLE: begin
                if (data_req && !data_done) begin
                    state_d = ARB_D_ADDR;
                    req_d   = 1'b1;
                    wr_d    = data_wr;
                    size_d  = data_size;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                end else if (inst_req && !inst_done) begin
                    state_d = ARB_I_ADDR;
                    req_d   = 1'b1;
                    wr_d    = 1'b0;
                    size_d  = SIZE_WORD;
                    addr_d  = inst_addr;
                    wdata_d = '0;
                end
            end
            ARB_D_ADDR: begin
                if (bus_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = bus_data_ok ? ARB_IDLE : ARB_D_DATA;
                end
            end
            ARB_D_DATA: begin
                if (bus_data_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_I_ADDR: begin
                if (bus_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = bus_data_ok ? ARB_IDLE : ARB_I_DATA;
                end
            end
            ARB_I_DATA: begin
                if (bus_data_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign data_active   = (state_q == ARB_D_ADDR) || (state_q == ARB_D_DATA);
    assign inst_active   = (state_q == ARB_I_ADDR) || (state_q == ARB_I_DATA);
    // data_ok only counts once the address phase is (or is being) accepted.
    assign data_complete = bus_data_ok && ((state_q == ARB_D_DATA) ||
                                           (state_q == ARB_D_ADDR && bus_addr_ok));
    assign inst_complete = bus_data_ok && ((state_q == ARB_I_DATA) ||
                                           (state_q == ARB_I_ADDR && bus_addr_ok));
    assign flush_idle    = except_flush && (state_q == ARB_IDLE);

    arb_req_slot #(.DATA_W(DATA_W)) u_inst_slot (
        .clk        (clk),
        .resetn     (resetn),
        .active     (inst_active),
        .complete   (inst_complete),
        .capture    (1'b1),
        .flush      (except_flush),
        .flush_idle (flush_idle),
        .cpu_stall  (cpu_stall),
        .bus_rdata  (bus_rdata),
        .done       (inst_done),
        .rdata      (inst_rdata)
    );

    // bus_wr still holds the write flag of the transaction in flight.
    arb_req_slot #(.DATA_W(DATA_W)) u_data_slot (
        .clk        (clk),
        .resetn     (resetn),
        .active     (data_active),
        .complete   (data_complete),
        .capture    (!bus_wr),
        .flush      (except_flush),
        .flush_idle (flush_idle),
        .cpu_stall  (cpu_stall),
        .bus_rdata  (bus_rdata),
        .done       (data_done),
        .rdata      (data_rdata)
    );

    assign stallreq_from_mem = data_req && !data_done;
    assign stallreq_from_if  = inst_req && !inst_done;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_if_wait  <= 32'd0;
            perf_mem_wait <= 32'd0;
        end else begin
            if (stallreq_from_if) begin
                perf_if_wait <= perf_if_wait + 32'd1;
            end
            if (stallreq_from_mem) begin
                perf_mem_wait <= perf_mem_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: a table of single transactions,
// hand-written multi-cycle sequences (priority, held result, flush, reset)
// and a randomized run against a transaction-level reference model.
// Build with ARB_PERF_CNT_EN to also check the wait counters.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              stallreq_from_if;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              stallreq_from_mem;
    logic              cpu_stall;
    logic              except_flush;
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       perf_if_wait;
    logic [31:0]       perf_mem_wait;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_rdata        (inst_rdata),
        .stallreq_from_if  (stallreq_from_if),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .stallreq_from_mem (stallreq_from_mem),
        .cpu_stall         (cpu_stall),
        .except_flush      (except_flush),
        .bus_req           (bus_req),
        .bus_wr            (bus_wr),
        .bus_size          (bus_size),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_addr_ok       (bus_addr_ok),
        .bus_data_ok       (bus_data_ok),
        .bus_rdata         (bus_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_wait      (perf_if_wait),
        .perf_mem_wait     (perf_mem_wait)
`endif
    );

    typedef struct {
        logic        isData;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  expSize;
        logic [31:0] expInst;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[6];

    // Reference model state (transaction level).
    bit          mCur, mIsData, mAcc, mDrop, mWr;
    logic [1:0]  mSize;
    logic [31:0] mAddr, mWdata;
    bit          mInstDone, mDataDone;
    logic [31:0] mInstHeld, mDataHeld;
    logic [31:0] mPerfIf, mPerfMem;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clearInputs();
        inst_req     = 1'b0;
        inst_addr    = '0;
        data_req     = 1'b0;
        data_wr      = 1'b0;
        data_size    = 2'd0;
        data_addr    = '0;
        data_wdata   = '0;
        cpu_stall    = 1'b0;
        except_flush = 1'b0;
        bus_addr_ok  = 1'b0;
        bus_data_ok  = 1'b0;
        bus_rdata    = '0;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        clearInputs();
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    // One complete zero-wait transaction from an idle arbiter.
    task automatic applyStimulus(input vec_t v);
        cpu_stall = 1'b1;
        if (v.isData) begin
            data_req   = 1'b1;
            data_wr    = v.wr;
            data_size  = v.size;
            data_addr  = v.addr;
            data_wdata = v.wdata;
        end else begin
            inst_req  = 1'b1;
            inst_addr = v.addr;
        end
        #1;
        checkOutput("tbl_stall_idle", v.isData ? stallreq_from_mem : stallreq_from_if, 1);
        checkOutput("tbl_req_idle", bus_req, 0);
        step();
        bus_addr_ok = 1'b1;
        #1;
        checkOutput("tbl_bus_req", bus_req, 1);
        checkOutput("tbl_bus_addr", bus_addr, v.addr);
        checkOutput("tbl_bus_size", bus_size, v.expSize);
        checkOutput("tbl_bus_wr", bus_wr, v.isData & v.wr);
        if (v.isData && v.wr) checkOutput("tbl_bus_wdata", bus_wdata, v.wdata);
        step();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = v.rdata;
        #1;
        checkOutput("tbl_req_dphase", bus_req, 0);
        checkOutput("tbl_stall_dphase", v.isData ? stallreq_from_mem : stallreq_from_if, 1);
        step();
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
        #1;
        checkOutput("tbl_stall_done", v.isData ? stallreq_from_mem : stallreq_from_if, 0);
        checkOutput("tbl_inst_rdata", inst_rdata, v.expInst);
        checkOutput("tbl_data_rdata", data_rdata, v.expData);
        cpu_stall = 1'b0;
        step();
        clearInputs();
        step();
    endtask

    initial begin
        clearInputs();
        resetn = 1'b0;
        #23;
        #1;
        checkOutput("rst_bus_req", bus_req, 0);
        checkOutput("rst_bus_addr", bus_addr, 0);
        checkOutput("rst_bus_size", bus_size, 0);
        checkOutput("rst_inst_rdata", inst_rdata, 0);
        checkOutput("rst_data_rdata", data_rdata, 0);
        resetn = 1'b1;
        step();

        // isData wr size addr wdata rdata expSize expInst expData
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'hBFC00000, 32'h0,      32'h24080001, 2'd2, 32'h24080001, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h80000003, 32'h000000AB, 32'h5555AAAA, 2'd0, 32'h24080001, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h80000010, 32'h0,      32'h12345678, 2'd2, 32'h24080001, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h80000022, 32'h0000BEEF, 32'h0BADF00D, 2'd1, 32'h24080001, 32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 32'hBFC00004, 32'h0,      32'h3C1D8000, 2'd2, 32'h3C1D8000, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 32'h80000001, 32'h0,      32'h000000A5, 2'd0, 32'h3C1D8000, 32'h000000A5};
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Simultaneous requests: data first, then fetch.
        inst_req = 1'b1; inst_addr = 32'hBFC00008;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80001000;
        cpu_stall = 1'b1;
        #1;
        checkOutput("sim_stall_mem0", stallreq_from_mem, 1);
        checkOutput("sim_stall_if0", stallreq_from_if, 1);
        step();
        bus_addr_ok = 1'b1;
        #1;
        checkOutput("sim_first_addr", bus_addr, 32'h80001000);
        checkOutput("sim_first_req", bus_req, 1);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11112222;
        #1;
        checkOutput("sim_stall_mem1", stallreq_from_mem, 1);
        step();
        bus_data_ok = 1'b0;
        #1;
        checkOutput("sim_stall_mem2", stallreq_from_mem, 0);
        checkOutput("sim_stall_if2", stallreq_from_if, 1);
        checkOutput("sim_data_rdata", data_rdata, 32'h11112222);
        step();
        bus_addr_ok = 1'b1;
        #1;
        checkOutput("sim_second_req", bus_req, 1);
        checkOutput("sim_second_addr", bus_addr, 32'hBFC00008);
        checkOutput("sim_second_size", bus_size, 2);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h33334444;
        #1;
        checkOutput("sim_stall_if3", stallreq_from_if, 1);
        step();
        bus_data_ok = 1'b0;
        #1;
        checkOutput("sim_stall_if4", stallreq_from_if, 0);
        checkOutput("sim_inst_rdata", inst_rdata, 32'h33334444);
        checkOutput("sim_data_keep", data_rdata, 32'h11112222);
        cpu_stall = 1'b0;
        step();
        clearInputs();
        step();

        // Held result across a 3-cycle stall, then a same-cycle addr/data reissue.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80002000;
        cpu_stall = 1'b1;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
        step();
        bus_data_ok = 1'b0; bus_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("hold_no_reissue", bus_req, 0);
            checkOutput("hold_stall_mem", stallreq_from_mem, 0);
            checkOutput("hold_rdata", data_rdata, 32'h12345678);
            step();
        end
        cpu_stall = 1'b0;
        data_addr = 32'h80002004;
        #1;
        checkOutput("hold_release_stall", stallreq_from_mem, 0);
        step();
        #1;
        checkOutput("hold_cleared_stall", stallreq_from_mem, 1);
        checkOutput("hold_cleared_req", bus_req, 0);
        cpu_stall = 1'b1;
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
        #1;
        checkOutput("hold_reissue_req", bus_req, 1);
        checkOutput("hold_reissue_addr", bus_addr, 32'h80002004);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        checkOutput("same_cycle_stall", stallreq_from_mem, 0);
        checkOutput("same_cycle_req", bus_req, 0);
        checkOutput("same_cycle_rdata", data_rdata, 32'hCAFEF00D);
        cpu_stall = 1'b0;
        step();
        clearInputs();
        step();

        // Flush during I_DATA: response consumed and dropped, then a fresh fetch.
        inst_req = 1'b1; inst_addr = 32'hBFC00040; cpu_stall = 1'b1;
        step();
        bus_addr_ok = 1'b1;
        #1;
        checkOutput("fl_addr", bus_addr, 32'hBFC00040);
        step();
        bus_addr_ok = 1'b0; except_flush = 1'b1;
        step();
        except_flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
        step();
        bus_data_ok = 1'b0; inst_addr = 32'hBFC00100;
        #1;
        checkOutput("fl_rdata_kept", inst_rdata, 32'h33334444);
        checkOutput("fl_stall_if", stallreq_from_if, 1);
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h8FA40000;
        #1;
        checkOutput("fl_refetch_req", bus_req, 1);
        checkOutput("fl_refetch_addr", bus_addr, 32'hBFC00100);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        checkOutput("fl_refetch_rdata", inst_rdata, 32'h8FA40000);
        checkOutput("fl_refetch_stall", stallreq_from_if, 0);
        except_flush = 1'b1;
        step();
        except_flush = 1'b0;
        #1;
        checkOutput("fl_idle_clears_done", stallreq_from_if, 1);
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h11110000;
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        #1;
        checkOutput("fl_idle_refetch", inst_rdata, 32'h11110000);
        cpu_stall = 1'b0;
        step();
        clearInputs();
        step();

        // Reset in D_DATA.
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80003000;
        cpu_stall = 1'b1;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("mr_bus_req", bus_req, 0);
        checkOutput("mr_bus_addr", bus_addr, 0);
        checkOutput("mr_bus_size", bus_size, 0);
        checkOutput("mr_inst_rdata", inst_rdata, 0);
        checkOutput("mr_data_rdata", data_rdata, 0);
`ifdef ARB_PERF_CNT_EN
        checkOutput("mr_perf_if", perf_if_wait, 0);
        checkOutput("mr_perf_mem", perf_mem_wait, 0);
`endif
        clearInputs();
        step();
        resetn = 1'b1;
        step();
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h00000001;
        #1;
        checkOutput("mr_idle_issue", bus_req, 1);
        step();
        clearInputs();
        step();

        // Randomized run against the transaction-level model.
        doReset();
        mCur = 0; mIsData = 0; mAcc = 0; mDrop = 0; mWr = 0; mSize = 0;
        mAddr = 0; mWdata = 0; mInstDone = 0; mDataDone = 0;
        mInstHeld = 0; mDataHeld = 0; mPerfIf = 0; mPerfMem = 0;
        for (int c = 0; c < 600; c++) begin
            bit wasIdle, fin, keep, startD, startI;
            inst_req     = ($urandom_range(99) < 75);
            inst_addr    = $urandom;
            data_req     = ($urandom_range(99) < 50);
            data_wr      = ($urandom_range(99) < 30);
            data_size    = 2'($urandom_range(2));
            data_addr    = $urandom;
            data_wdata   = $urandom;
            cpu_stall    = ($urandom_range(99) < 30);
            except_flush = ($urandom_range(99) < 5);
            bus_addr_ok  = ($urandom_range(99) < 60);
            bus_data_ok  = ($urandom_range(99) < 50);
            bus_rdata    = $urandom;
            #1;
            checkOutput("rnd_bus_req", bus_req, mCur && !mAcc);
            if (mCur && !mAcc) begin
                checkOutput("rnd_bus_addr", bus_addr, mAddr);
                checkOutput("rnd_bus_wr", bus_wr, mWr);
                checkOutput("rnd_bus_size", bus_size, mSize);
                if (mWr) checkOutput("rnd_bus_wdata", bus_wdata, mWdata);
            end
            checkOutput("rnd_stall_if", stallreq_from_if, inst_req && !mInstDone);
            checkOutput("rnd_stall_mem", stallreq_from_mem, data_req && !mDataDone);
            checkOutput("rnd_inst_rdata", inst_rdata, mInstHeld);
            checkOutput("rnd_data_rdata", data_rdata, mDataHeld);
`ifdef ARB_PERF_CNT_EN
            checkOutput("rnd_perf_if", perf_if_wait, mPerfIf);
            checkOutput("rnd_perf_mem", perf_mem_wait, mPerfMem);
            if (inst_req && !mInstDone) mPerfIf = mPerfIf + 1;
            if (data_req && !mDataDone) mPerfMem = mPerfMem + 1;
`endif
            wasIdle = !mCur;
            fin     = 0;
            keep    = 0;
            startD  = wasIdle && data_req && !mDataDone;
            startI  = wasIdle && !startD && inst_req && !mInstDone;
            if (mCur) begin
                if (!mAcc) begin
                    if (bus_addr_ok) begin
                        mAcc = 1;
                        fin  = bus_data_ok;
                    end
                end else begin
                    fin = bus_data_ok;
                end
                if (fin) keep = !(mDrop || except_flush);
                else if (except_flush) mDrop = 1;
            end
            if (fin && mIsData) begin
                if (keep) begin
                    mDataDone = 1;
                    if (!mWr) mDataHeld = bus_rdata;
                end
            end else if (except_flush && wasIdle) mDataDone = 0;
            else if (!cpu_stall) mDataDone = 0;
            if (fin && !mIsData) begin
                if (keep) begin
                    mInstDone = 1;
                    mInstHeld = bus_rdata;
                end
            end else if (except_flush && wasIdle) mInstDone = 0;
            else if (!cpu_stall) mInstDone = 0;
            if (fin) mCur = 0;
            if (startD) begin
                mCur = 1; mIsData = 1; mAcc = 0; mDrop = 0;
                mAddr = data_addr; mWr = data_wr; mSize = data_size; mWdata = data_wdata;
            end else if (startI) begin
                mCur = 1; mIsData = 0; mAcc = 0; mDrop = 0;
                mAddr = inst_addr; mWr = 0; mSize = 2'd2; mWdata = 0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
